// File: rtl/ising_config_pkg.sv
// ising_config: shared constants for the fabric configuration-register space.
// Holds the GPIO word layout used by the PS bridge and the bridge FSM state type.
package ising_config;

    // GPIO write word from the PS: address [15:0], data [23:16], write clock [24].
    localparam int unsigned gpio_addr_lsb   = 0;
    localparam int unsigned gpio_addr_width = 16;
    localparam int unsigned gpio_data_lsb   = 16;
    localparam int unsigned gpio_data_width = 8;
    localparam int unsigned gpio_w_clk_bit  = 24;

    // GPIO readback word to the PS.
    localparam int unsigned gpio_rb_data_lsb = 0;
    localparam int unsigned gpio_rb_addr_lsb = 8;
    localparam int unsigned gpio_ack_bit     = 24;
    localparam int unsigned gpio_ovr_bit     = 25;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StReadWait,
        StAck
    } gpio_bridge_state_t;

endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: STAGES-deep single-bit synchroniser with registered edge flags.
// Ports:
//   clk_i, rst_i    fabric clock, synchronous active-high reset
//   d_i             asynchronous input
//   level_o         synchronised level (last chain stage)
//   level_next_o    value level_o will take next cycle (second-to-last stage)
//   rise_o, fall_o  one-cycle flags, high in the cycle level_o changes
//   valid_o         high once the chain holds only real samples after reset
module gpio_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic level_next_o,
    output logic rise_o,
    output logic fall_o,
    output logic valid_o
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic [STAGES-1:0] fill_q, fill_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
        fill_d = {fill_q[STAGES-2:0], 1'b1};
        // Edges are computed one stage early so they line up with level_o.
        rise_d = sync_q[STAGES-2] & ~sync_q[STAGES-1];
        fall_d = ~sync_q[STAGES-2] & sync_q[STAGES-1];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            fill_q <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            fill_q <= fill_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign level_o      = sync_q[STAGES-1];
    assign level_next_o = sync_q[STAGES-2];
    assign rise_o       = rise_q;
    assign fall_o       = fall_q;
    assign valid_o      = fill_q[STAGES-1];

endmodule

// File: rtl/gpio_reg_bridge.sv
// gpio_reg_bridge: PS GPIO channel to fabric config-register bridge.
// A rising w_clk on gpio_in issues one write strobe for the synced address/data,
// then returns the readback value and address echo with a level ack.
// Ports:
//   clk, rst   fabric clock, synchronous active-high reset
//   gpio_in    PS GPIO word: addr [15:0], data [23:16], w_clk [24]
//   gpio_out   rb data [7:0], addr echo [23:8], ack [24], sticky overrun [25]
//   wr_en      one-cycle write strobe; wr_addr/wr_data valid while high
//   rd_addr    address to the readback mux, held until the next capture
//   rd_data    readback mux result, valid RD_LAT cycles after rd_addr
module gpio_reg_bridge
    import ising_config::*;
#(
    parameter int unsigned RD_LAT      = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                gpio_in,
    output logic [31:0]                gpio_out,
    output logic                       wr_en,
    output logic [gpio_addr_width-1:0] wr_addr,
    output logic [gpio_data_width-1:0] wr_data,
    output logic [gpio_addr_width-1:0] rd_addr,
    input  logic [gpio_data_width-1:0] rd_data
);

    localparam int unsigned AdW      = gpio_addr_width + gpio_data_width;
    localparam logic [3:0]  RdLatCnt = 4'(RD_LAT);

    // Address/data bits share the w_clk chain depth so they arrive together.
    logic [AdW-1:0] ad_sync_q [SYNC_STAGES];
    logic [AdW-1:0] ad_sync_d [SYNC_STAGES];
    logic [AdW-1:0] ad_synced;
    logic [gpio_addr_width-1:0] sync_addr;
    logic [gpio_data_width-1:0] sync_data;

    logic wclk_level, wclk_next, wclk_rise, wclk_valid;
    logic unused_wclk_fall;
    logic unused_gpio_hi;

    gpio_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_wclk_sync (
        .clk_i        (clk),
        .rst_i        (rst),
        .d_i          (gpio_in[gpio_w_clk_bit]),
        .level_o      (wclk_level),
        .level_next_o (wclk_next),
        .rise_o       (wclk_rise),
        .fall_o       (unused_wclk_fall),
        .valid_o      (wclk_valid)
    );

    assign unused_gpio_hi = ^gpio_in[31:gpio_w_clk_bit+1];

    always_comb begin
        ad_sync_d[0] = gpio_in[AdW-1:0];
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            ad_sync_d[i] = ad_sync_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                ad_sync_q[i] <= '0;
            end
        end else begin
            ad_sync_q <= ad_sync_d;
        end
    end

    assign ad_synced = ad_sync_q[SYNC_STAGES-1];
    assign sync_addr = ad_synced[gpio_addr_lsb +: gpio_addr_width];
    assign sync_data = ad_synced[gpio_data_lsb +: gpio_data_width];

    gpio_bridge_state_t         state_q, state_d;
    logic [3:0]                 cnt_q, cnt_d;
    logic                       armed_q, armed_d;
    logic [gpio_addr_width-1:0] wr_addr_q, wr_addr_d;
    logic [gpio_data_width-1:0] wr_data_q, wr_data_d;
    logic [gpio_addr_width-1:0] rd_addr_q, rd_addr_d;
    logic [gpio_data_width-1:0] rb_data_q, rb_data_d;
    logic [gpio_addr_width-1:0] rb_addr_q, rb_addr_d;
    logic                       ack_q, ack_d;
    logic                       ovr_q, ovr_d;
    logic                       rise_armed;

    assign rise_armed = wclk_rise & armed_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_addr_d = rd_addr_q;
        rb_data_d = rb_data_q;
        rb_addr_d = rb_addr_q;
        ack_d     = ack_q;
        // Only a low level seen after the chain has flushed counts: the reset
        // zeros in the chain must not arm a w_clk that is really held high.
        armed_d   = armed_q | (wclk_valid & ~wclk_level);
        // A rise while busy is dropped but remembered until reset.
        ovr_d     = ovr_q | (rise_armed & (state_q != StIdle));

        unique case (state_q)
            StIdle: begin
                if (rise_armed) begin
                    wr_addr_d = sync_addr;
                    wr_data_d = sync_data;
                    rd_addr_d = sync_addr;
                    state_d   = StWrite;
                end
            end
            StWrite: begin
                cnt_d = RdLatCnt;
                if (RD_LAT == 1) begin
                    rb_data_d = rd_data;
                    rb_addr_d = rd_addr_q;
                    ack_d     = 1'b1;
                    state_d   = StAck;
                end else begin
                    state_d = StReadWait;
                end
            end
            StReadWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd2) begin
                    rb_data_d = rd_data;
                    rb_addr_d = rd_addr_q;
                    ack_d     = 1'b1;
                    state_d   = StAck;
                end
            end
            StAck: begin
                // Look one stage ahead so ack drops SYNC_STAGES cycles after the
                // pin falls, and one cycle after entry if w_clk is already low.
                if (!wclk_next) begin
                    ack_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            armed_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_addr_q <= '0;
            rb_data_q <= '0;
            rb_addr_q <= '0;
            ack_q     <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_addr_q <= rd_addr_d;
            rb_data_q <= rb_data_d;
            rb_addr_q <= rb_addr_d;
            ack_q     <= ack_d;
            ovr_q     <= ovr_d;
        end
    end

    // Gated with rst so a reset raised in the WRITE cycle still kills the strobe.
    assign wr_en   = (state_q == StWrite) & ~rst;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign rd_addr = rd_addr_q;

    always_comb begin
        gpio_out = '0;
        gpio_out[gpio_rb_data_lsb +: gpio_data_width] = rb_data_q;
        gpio_out[gpio_rb_addr_lsb +: gpio_addr_width] = rb_addr_q;
        gpio_out[gpio_ack_bit] = ack_q;
        gpio_out[gpio_ovr_bit] = ovr_q;
    end

endmodule

// File: tb/tb_gpio_reg_bridge.sv
// Directed bench for gpio_reg_bridge (RD_LAT = 2, SYNC_STAGES = 2).
// Cycle 0 is the cycle in which the w_clk change is driven on gpio_in.
module tb_gpio_reg_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] gpio_in = '0;
    logic [31:0] gpio_out;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    bit wr_prev = 1'b0;

    gpio_reg_bridge #(
        .RD_LAT      (2),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    always #5 clk = ~clk;

    // Readback mux model: 0xA5 at 0x0014, otherwise low address byte ^ 0x3C.
    assign rd_data = (rd_addr == 16'h0014) ? 8'hA5 : (rd_addr[7:0] ^ 8'h3C);

    // Count strobes and flag any back-to-back wr_en.
    always @(posedge clk) begin
        if (wr_en) begin
            wr_cnt++;
            checks++;
            if (wr_prev) begin
                errors++;
                $display("FAIL wr_en_consecutive: wr_en high two cycles in a row at %0t", $time);
            end
        end
        wr_prev <= wr_en;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        gpio_in = 32'h0001_000C;
        tick(3);
        checks += 5;
        if (gpio_out !== 32'h0) begin errors++; $display("FAIL reset_gpio_out: got %h want 0", gpio_out); end
        if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
        if (wr_addr !== 16'h0) begin errors++; $display("FAIL reset_wr_addr: got %h want 0", wr_addr); end
        if (wr_data !== 8'h0) begin errors++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
        if (rd_addr !== 16'h0) begin errors++; $display("FAIL reset_rd_addr: got %h want 0", rd_addr); end
        rst = 1'b0;
        tick(5);
    endtask

    task automatic test_basic_write();
        int w0 = wr_cnt;
        gpio_in = 32'h0101_000C;
        for (int c = 1; c <= 6; c++) begin
            tick(1);
            checks += 2;
            if (wr_en !== (c == 3)) begin
                errors++; $display("FAIL basic_wr_en c%0d: got %b want %b", c, wr_en, (c == 3));
            end
            if (gpio_out[24] !== (c >= 5)) begin
                errors++; $display("FAIL basic_ack c%0d: got %b want %b", c, gpio_out[24], (c >= 5));
            end
            if (c == 3) begin
                checks += 3;
                if (wr_addr !== 16'h000C) begin errors++; $display("FAIL basic_wr_addr: got %h want 000c", wr_addr); end
                if (wr_data !== 8'h01) begin errors++; $display("FAIL basic_wr_data: got %h want 01", wr_data); end
                if (rd_addr !== 16'h000C) begin errors++; $display("FAIL basic_rd_addr: got %h want 000c", rd_addr); end
            end
            if (c == 5) begin
                checks += 2;
                if (gpio_out[23:8] !== 16'h000C) begin errors++; $display("FAIL basic_echo: got %h want 000c", gpio_out[23:8]); end
                if (gpio_out[7:0] !== 8'h30) begin errors++; $display("FAIL basic_rb_data: got %h want 30", gpio_out[7:0]); end
            end
        end
        tick(1);
        gpio_in = 32'h0001_000C;
        tick(1);
        checks++;
        if (gpio_out[24] !== 1'b1) begin errors++; $display("FAIL basic_ack_hold: got %b want 1", gpio_out[24]); end
        tick(1);
        checks += 2;
        if (gpio_out[24] !== 1'b0) begin errors++; $display("FAIL basic_ack_fall: got %b want 0", gpio_out[24]); end
        if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL basic_wr_count: got %0d want 1", wr_cnt - w0); end
        tick(3);
    endtask

    task automatic test_readback();
        gpio_in = 32'h0000_0014;
        tick(2);
        gpio_in = 32'h0100_0014;
        tick(5);
        checks += 3;
        if (gpio_out[7:0] !== 8'hA5) begin errors++; $display("FAIL rb_data: got %h want a5", gpio_out[7:0]); end
        if (gpio_out[23:8] !== 16'h0014) begin errors++; $display("FAIL rb_echo: got %h want 0014", gpio_out[23:8]); end
        if (gpio_out[24] !== 1'b1) begin errors++; $display("FAIL rb_ack_rise: got %b want 1", gpio_out[24]); end
        tick(4);
        checks++;
        if (gpio_out[24] !== 1'b1) begin errors++; $display("FAIL rb_ack_held: got %b want 1", gpio_out[24]); end
        gpio_in = 32'h0000_0014;
        tick(1);
        checks++;
        if (gpio_out[24] !== 1'b1) begin errors++; $display("FAIL rb_ack_c1: got %b want 1", gpio_out[24]); end
        tick(1);
        checks += 2;
        if (gpio_out[24] !== 1'b0) begin errors++; $display("FAIL rb_ack_c2: got %b want 0", gpio_out[24]); end
        if (gpio_out[7:0] !== 8'hA5) begin errors++; $display("FAIL rb_data_hold: got %h want a5", gpio_out[7:0]); end
        tick(3);
    endtask

    task automatic test_held_high();
        int w0 = wr_cnt;
        rst = 1'b1;
        gpio_in = 32'h0102_0020;
        tick(3);
        rst = 1'b0;
        tick(10);
        checks += 2;
        if (wr_cnt !== w0) begin errors++; $display("FAIL held_no_write: got %0d writes want 0", wr_cnt - w0); end
        if (gpio_out !== 32'h0) begin errors++; $display("FAIL held_gpio_out: got %h want 0", gpio_out); end
        gpio_in = 32'h0002_0020;
        tick(4);
        gpio_in = 32'h0102_0020;
        tick(10);
        checks += 4;
        if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL held_one_write: got %0d want 1", wr_cnt - w0); end
        if (gpio_out[23:8] !== 16'h0020) begin errors++; $display("FAIL held_echo: got %h want 0020", gpio_out[23:8]); end
        if (gpio_out[7:0] !== 8'h1C) begin errors++; $display("FAIL held_rb_data: got %h want 1c", gpio_out[7:0]); end
        if (gpio_out[24] !== 1'b1) begin errors++; $display("FAIL held_ack: got %b want 1", gpio_out[24]); end
        gpio_in = 32'h0002_0020;
        tick(4);
        checks++;
        if (gpio_out[24] !== 1'b0) begin errors++; $display("FAIL held_ack_clear: got %b want 0", gpio_out[24]); end
    endtask

    task automatic test_overrun();
        int w0 = wr_cnt;
        gpio_in = 32'h0033_0030;
        tick(2);
        gpio_in = 32'h0133_0030;
        tick(1);
        gpio_in = 32'h0033_0030;
        tick(1);
        gpio_in = 32'h0133_0030;
        tick(1);
        checks += 4;
        if (wr_en !== 1'b1) begin errors++; $display("FAIL ovr_wr_en: got %b want 1", wr_en); end
        if (wr_addr !== 16'h0030) begin errors++; $display("FAIL ovr_wr_addr: got %h want 0030", wr_addr); end
        if (wr_data !== 8'h33) begin errors++; $display("FAIL ovr_wr_data: got %h want 33", wr_data); end
        if (gpio_out[25] !== 1'b0) begin errors++; $display("FAIL ovr_early_c3: got %b want 0", gpio_out[25]); end
        tick(1);
        checks++;
        if (gpio_out[25] !== 1'b0) begin errors++; $display("FAIL ovr_early_c4: got %b want 0", gpio_out[25]); end
        tick(1);
        checks += 4;
        if (gpio_out[25] !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", gpio_out[25]); end
        if (gpio_out[24] !== 1'b1) begin errors++; $display("FAIL ovr_ack: got %b want 1", gpio_out[24]); end
        if (gpio_out[23:8] !== 16'h0030) begin errors++; $display("FAIL ovr_echo: got %h want 0030", gpio_out[23:8]); end
        if (gpio_out[7:0] !== 8'h0C) begin errors++; $display("FAIL ovr_rb_data: got %h want 0c", gpio_out[7:0]); end
        tick(5);
        gpio_in = 32'h0033_0030;
        tick(4);
        checks += 3;
        if (gpio_out[24] !== 1'b0) begin errors++; $display("FAIL ovr_ack_clear: got %b want 0", gpio_out[24]); end
        if (gpio_out[25] !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", gpio_out[25]); end
        if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL ovr_one_write: got %0d want 1", wr_cnt - w0); end
    endtask

    task automatic test_one_cycle_pulse();
        int w0 = wr_cnt;
        gpio_in = 32'h0044_0040;
        tick(2);
        gpio_in = 32'h0144_0040;
        tick(1);
        gpio_in = 32'h0044_0040;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) tick(1);
            checks += 2;
            if (wr_en !== (c == 3)) begin
                errors++; $display("FAIL pulse_wr_en c%0d: got %b want %b", c, wr_en, (c == 3));
            end
            if (gpio_out[24] !== (c == 5)) begin
                errors++; $display("FAIL pulse_ack c%0d: got %b want %b", c, gpio_out[24], (c == 5));
            end
            if (c == 3) begin
                checks += 2;
                if (wr_addr !== 16'h0040) begin errors++; $display("FAIL pulse_wr_addr: got %h want 0040", wr_addr); end
                if (wr_data !== 8'h44) begin errors++; $display("FAIL pulse_wr_data: got %h want 44", wr_data); end
            end
        end
        checks += 2;
        if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL pulse_one_write: got %0d want 1", wr_cnt - w0); end
        if (gpio_out[25] !== 1'b1) begin errors++; $display("FAIL pulse_ovr_sticky: got %b want 1", gpio_out[25]); end
    endtask

    task automatic test_rst_mid();
        int w0 = wr_cnt;
        gpio_in = 32'h0055_0050;
        tick(2);
        gpio_in = 32'h0155_0050;
        tick(2);
        rst = 1'b1;
        tick(1);
        checks++;
        if (wr_en !== 1'b0) begin errors++; $display("FAIL rstmid_wr_en_c3: got %b want 0", wr_en); end
        tick(1);
        checks++;
        if (wr_en !== 1'b0) begin errors++; $display("FAIL rstmid_wr_en_c4: got %b want 0", wr_en); end
        rst = 1'b0;
        checks += 4;
        if (gpio_out !== 32'h0) begin errors++; $display("FAIL rstmid_gpio_out: got %h want 0", gpio_out); end
        if (wr_addr !== 16'h0) begin errors++; $display("FAIL rstmid_wr_addr: got %h want 0", wr_addr); end
        if (wr_data !== 8'h0) begin errors++; $display("FAIL rstmid_wr_data: got %h want 0", wr_data); end
        if (rd_addr !== 16'h0) begin errors++; $display("FAIL rstmid_rd_addr: got %h want 0", rd_addr); end
        tick(6);
        checks += 2;
        if (wr_cnt !== w0) begin errors++; $display("FAIL rstmid_no_write: got %0d writes want 0", wr_cnt - w0); end
        if (gpio_out !== 32'h0) begin errors++; $display("FAIL rstmid_gpio_out_late: got %h want 0", gpio_out); end
        gpio_in = 32'h0055_0050;
        tick(4);
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_readback();
        test_held_high();
        test_overrun();
        test_one_cycle_pulse();
        test_rst_mid();
        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
